div3_serial: RTL and testbench

DIV3_SERIAL -- requirements
Module: div3_serial

---
 rtl/div_pkg.sv | 18 +
 rtl/div3_step.sv | 23 ++
 rtl/div3_serial.sv | 92 +++++++++
 tb/tb_div3_serial.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the serial divide-by-3 block: FSM encoding,
// remainder width and the bit-counter width rule.
package div_pkg;

  localparam int REM_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold the value DATA_W itself, not just DATA_W-1.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/div3_step.sv
// One restoring-division step by 3: folds the next dividend bit into the
// running remainder and yields the quotient bit.
module div3_step
  import div_pkg::*;
(
  input  logic [REM_W-1:0] rem,
  input  logic             data_bit,
  output logic             qbit,
  output logic [REM_W-1:0] rem_next
);

  logic [2:0] t;
  logic [2:0] t_sub;

  // rem stays in 0..2, so t = 2*rem + bit never exceeds 5.
  always_comb begin
    t        = {rem, data_bit};
    qbit     = (t >= 3'd3);
    t_sub    = qbit ? (t - 3'd3) : t;
    rem_next = t_sub[REM_W-1:0];
  end

endmodule

// File: rtl/div3_serial.sv
// Serial unsigned divide-by-3, MSB first, one bit per clock, with
// valid/ready handshakes on the dividend and result sides.
module div3_serial
  import div_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] quotient,
  output logic [REM_W-1:0]  remainder,
  output logic              divisible
);

  localparam int CNT_W = cnt_width(DATA_W);

  state_t             state_reg;
  logic [DATA_W-1:0]  shift_reg;
  logic [DATA_W-1:0]  q_work_reg;
  logic [REM_W-1:0]   rem_work_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [DATA_W-1:0]  quotient_reg;
  logic [REM_W-1:0]   remainder_reg;

  logic               step_qbit;
  logic [REM_W-1:0]   step_rem_next;
  logic [DATA_W-1:0]  q_work_next;

  div3_step u_step (
    .rem      (rem_work_reg),
    .data_bit (shift_reg[DATA_W-1]),
    .qbit     (step_qbit),
    .rem_next (step_rem_next)
  );

  assign q_work_next = (q_work_reg << 1) | DATA_W'(step_qbit);

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign divisible = (remainder_reg == '0);

  // Working registers are separate from the result registers so the ports
  // keep showing the last completed result while a new division runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      q_work_reg    <= '0;
      rem_work_reg  <= '0;
      cnt_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            state_reg    <= RUN;
            shift_reg    <= in_data;
            q_work_reg   <= '0;
            rem_work_reg <= '0;
            cnt_reg      <= CNT_W'(DATA_W);
          end
        end
        RUN: begin
          shift_reg    <= shift_reg << 1;
          q_work_reg   <= q_work_next;
          rem_work_reg <= step_rem_next;
          cnt_reg      <= cnt_reg - 1'b1;
          if (cnt_reg == CNT_W'(1)) begin
            state_reg     <= DONE;
            quotient_reg  <= q_work_next;
            remainder_reg <= step_rem_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div3_serial.sv
// Self-checking bench for div3_serial (DATA_W = 8) against an arithmetic
// reference (d / 3, d % 3), with random backpressure and input noise.
module tb_div3_serial;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] quotient;
  logic [1:0]        remainder;
  logic              divisible;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div3_serial #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .divisible (divisible)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One full transaction; all driving and sampling happens on falling edges.
  // hold: cycles of backpressure once the result is up (0 = out_ready high
  // throughout). noisy: keep in_valid high with random data while busy.
  task automatic run_op(input logic [DATA_W-1:0] d, input int hold, input bit noisy);
    int lat;
    logic [DATA_W-1:0] exp_q;
    logic [1:0] exp_r;
    exp_q = DATA_W'(int'(d) / 3);
    exp_r = 2'(int'(d) % 3);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = noisy;
    in_data  = DATA_W'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      check("busy_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      lat++;
      in_data = DATA_W'($urandom);
    end
    in_valid = 1'b0;
    check("latency", 32'(lat), 32'(DATA_W));
    check("quotient", 32'(quotient), 32'(exp_q));
    check("remainder", 32'(remainder), 32'(exp_r));
    check("divisible", 32'(divisible), 32'(exp_r == 2'd0));
    check("rem_not_3", 32'(remainder == 2'd3), 32'd0);
    check("done_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_quotient", 32'(quotient), 32'(exp_q));
      check("hold_remainder", 32'(remainder), 32'(exp_r));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_quotient", 32'(quotient), 32'(exp_q));
    $display("op d=%0d q=%0d r=%0d div=%0d lat=%0d hold=%0d noisy=%0d",
             d, quotient, remainder, divisible, lat, hold, noisy);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_divisible", 32'(divisible), 32'd1);

    // Latency / basic result
    run_op(8'd100, 0, 1'b0);
    // Back-to-back with busy-time noise on the input
    run_op(8'd255, 0, 1'b1);
    run_op(8'd0,   0, 1'b1);
    run_op(8'd254, 0, 1'b1);
    // Long backpressure
    run_op(8'd7, 20, 1'b0);

    // Reset during the 4th RUN cycle aborts the operation
    in_valid = 1'b1;
    in_data  = 8'd9;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    $display("op reset-abort d=9");
    run_op(8'd9, 0, 1'b0);

    // Exhaustive sweep with random backpressure and input noise
    for (int d = 0; d < 256; d++) begin
      run_op(DATA_W'(d), int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
